// File: rtl/lce_probe_capture.sv
// Trigger/capture buffer for LCE probe words: selectable channel, masked-compare trigger,
// circular pre-trigger history, post-trigger capture and oldest-first valid/ready drain.
module lce_probe_capture #(
    parameter int N_CH    = 4,
    parameter int PROBE_W = 32,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_CH*PROBE_W-1:0] probes_i,
    input  logic [CW-1:0]           ch_sel_i,
    input  logic                    mode_i,
    input  logic                    arm_i,
    input  logic [PROBE_W-1:0]      trig_mask_i,
    input  logic [PROBE_W-1:0]      trig_value_i,
    input  logic [AW-1:0]           post_cnt_i,
    output logic [PROBE_W-1:0]      rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [1:0]              state_o,
    output logic [AW:0]             level_o,
    output logic                    wrap_o,
    output logic                    alarm_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW:0]        level_q, level_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      remaining_q, remaining_d;
    logic               wrap_q, wrap_d;
    logic [CW-1:0]      ch_sel_q, ch_sel_d;
    logic               mode_q, mode_d;
    logic [PROBE_W-1:0] mask_q, mask_d;
    logic [PROBE_W-1:0] value_q, value_d;
    logic [AW-1:0]      post_q, post_d;

    logic [PROBE_W-1:0] mem [DEPTH];
    logic [PROBE_W-1:0] ch_words [N_CH];
    logic [PROBE_W-1:0] sample;
    logic               match;
    logic               mem_we;
    logic               rd_valid;

    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            ch_words[c] = probes_i[c*PROBE_W +: PROBE_W];
        end
    end

    assign sample   = ch_words[ch_sel_q];
    assign match    = ((sample ^ value_q) & mask_q) == '0;
    assign rd_valid = (state_q == DONE) && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        wrap_d      = wrap_q;
        ch_sel_d    = ch_sel_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        value_d     = value_q;
        post_d      = post_q;
        mem_we      = 1'b0;

        if (arm_i) begin
            ch_sel_d    = ch_sel_i;
            mode_d      = mode_i;
            mask_d      = trig_mask_i;
            value_d     = trig_value_i;
            post_d      = post_cnt_i;
            level_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            remaining_d = '0;
            wrap_d      = 1'b0;
            state_d     = ARMED;
        end else begin
            case (state_q)
                ARMED, CAPTURE: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Full buffer: the write slot is the oldest entry, so the read side advances too.
                    if (level_q == LVL_FULL) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        if (state_q == ARMED) begin
                            wrap_d = 1'b1;
                        end
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                    if (state_q == ARMED) begin
                        if (match) begin
                            if (post_q == '0) begin
                                state_d = DONE;
                            end else begin
                                state_d     = CAPTURE;
                                remaining_d = post_q;
                            end
                        end
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == AW'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (rd_valid && rd_ready_i) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        level_d  = level_q - 1'b1;
                        if (level_q == (AW+1)'(1)) begin
                            if (mode_q) begin
                                state_d  = ARMED;
                                wr_ptr_d = '0;
                                rd_ptr_d = '0;
                                wrap_d   = 1'b0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            ch_sel_q    <= '0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            value_q     <= '0;
            post_q      <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            ch_sel_q    <= ch_sel_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            post_q      <= post_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= sample;
        end
    end

    assign rd_valid_o = rd_valid;
    assign rd_data_o  = rd_valid ? mem[rd_ptr_q] : '0;
    assign state_o    = state_q;
    assign level_o    = level_q;
    assign wrap_o     = wrap_q;
    assign alarm_o    = (state_q == DONE);

endmodule

// File: tb/tb_lce_probe_capture.sv
// Bench for lce_probe_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lce_probe_capture;

    localparam int N_CH    = 4;
    localparam int PROBE_W = 32;
    localparam int DEPTH   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] probes;
    logic [1:0]   ch_sel;
    logic         mode;
    logic         arm;
    logic [31:0]  mask;
    logic [31:0]  val;
    logic [3:0]   post;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [1:0]   state;
    logic [4:0]   level;
    logic         wrap;
    logic         alarm;

    logic [31:0]  ch [4];
    always_comb probes = {ch[3], ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    lce_probe_capture #(.N_CH(N_CH), .PROBE_W(PROBE_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .probes_i(probes), .ch_sel_i(ch_sel), .mode_i(mode),
        .arm_i(arm), .trig_mask_i(mask), .trig_value_i(val), .post_cnt_i(post),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .state_o(state), .level_o(level), .wrap_o(wrap), .alarm_o(alarm)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 armed, 2 capture, 3 done; buffer is a plain queue.
    int          m_st;
    logic [31:0] m_q [$];
    bit          m_wrap;
    int          m_rem;
    int          m_ch;
    bit          m_mode;
    logic [31:0] m_mask, m_val;
    int          m_post;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_q.delete(); m_wrap = 0; m_rem = 0;
        m_ch = 0; m_mode = 0; m_mask = '0; m_val = '0; m_post = 0;
    endtask

    task automatic model_push(input logic [31:0] s, input bit mark_wrap);
        if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            if (mark_wrap) m_wrap = 1;
        end
        m_q.push_back(s);
    endtask

    task automatic model_edge();
        logic [31:0] s;
        s = ch[m_ch];
        if (arm) begin
            m_ch = int'(ch_sel); m_mode = mode; m_mask = mask; m_val = val; m_post = int'(post);
            m_q.delete(); m_wrap = 0; m_rem = 0; m_st = 1;
        end else if (m_st == 1) begin
            model_push(s, 1);
            if (((s ^ m_val) & m_mask) == 0) begin
                if (m_post == 0) m_st = 3;
                else begin m_st = 2; m_rem = m_post; end
            end
        end else if (m_st == 2) begin
            model_push(s, 0);
            m_rem--;
            if (m_rem == 0) m_st = 3;
        end else if (m_st == 3) begin
            if (m_q.size() > 0 && rd_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_mode) begin m_st = 1; m_wrap = 0; end
                    else m_st = 0;
                end
            end
        end
    endtask

    task automatic compare();
        bit          ev;
        logic [31:0] ed;
        ev = (m_st == 3) && (m_q.size() > 0);
        ed = ev ? m_q[0] : 32'h0;
        chk("state", 32'(state), 32'(m_st));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("rd_data", rd_data, ed);
        chk("alarm", 32'(alarm), 32'(m_st == 3));
    endtask

    // Inputs are set after a falling edge; outputs checked 1ns later, model stepped on the rising edge.
    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_probes();
        for (int i = 0; i < 4; i++) ch[i] = $urandom;
    endtask

    task automatic arm_cfg(input logic [1:0] c, input logic md, input logic [31:0] mk,
                           input logic [31:0] v, input logic [3:0] p);
        ch_sel = c; mode = md; mask = mk; val = v; post = p;
        arm = 1'b1;
        rand_probes();
        tick();
        arm = 1'b0;
    endtask

    int ctr;
    task automatic run_ctr(input int n);
        for (int i = 0; i < n; i++) begin
            rand_probes();
            ch[2] = 32'(ctr);
            tick();
            ctr++;
        end
    endtask

    task automatic drain_count(input int n, input int first);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_word", rd_data, 32'(first + i));
            tick();
        end
    endtask

    logic [31:0] words [$];
    logic [31:0] tmp, prev_data;
    bit          prev_stall;

    initial begin
        rst = 1'b1; arm = 1'b0; rd_ready = 1'b0;
        ch_sel = '0; mode = 1'b0; mask = '0; val = '0; post = '0;
        rand_probes();
        model_reset();
        @(negedge clk);
        do_reset();
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_data", rd_data, 32'h0);

        // 1: counting channel, trigger at 0x10, three post samples, history wraps
        arm_cfg(2'd2, 1'b0, 32'hFFFF_FFFF, 32'h10, 4'd3);
        ctr = 0;
        run_ctr(17);
        chk("t1_capture", 32'(state), 32'h2);
        run_ctr(2);
        chk("t1_still_capture", 32'(state), 32'h2);
        run_ctr(1);
        chk("t1_done", 32'(state), 32'h3);
        chk("t1_level", 32'(level), 32'd16);
        chk("t1_model_level", 32'(m_q.size()), 32'd16);
        chk("t1_wrap", 32'(wrap), 32'h1);
        chk("t1_model_head", m_q[0], 32'h04);
        drain_count(16, 4);
        chk("t1_idle", 32'(state), 32'h0);
        chk("t1_data_zero", rd_data, 32'h0);
        rd_ready = 1'b0;

        // 2: mask 0 triggers on the first sample, post 0
        arm_cfg(2'd1, 1'b0, 32'h0, 32'h1234, 4'd0);
        rand_probes();
        tmp = ch[1];
        tick();
        chk("t2_done", 32'(state), 32'h3);
        chk("t2_level", 32'(level), 32'd1);
        chk("t2_word", rd_data, tmp);
        rd_ready = 1'b1;
        tick();
        chk("t2_idle", 32'(state), 32'h0);
        rd_ready = 1'b0;

        // 3: trigger on the third armed sample, two post samples
        arm_cfg(2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 4'd2);
        words.delete();
        for (int i = 0; i < 5; i++) begin
            rand_probes();
            tmp = ch[1];
            tmp[31] = 1'b1;
            if (i == 2) tmp = 32'h0000_ABCD;
            ch[1] = tmp;
            words.push_back(tmp);
            tick();
        end
        chk("t3_done", 32'(state), 32'h3);
        chk("t3_level", 32'(level), 32'd5);
        chk("t3_wrap", 32'(wrap), 32'h0);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_word", rd_data, words[i]);
            tick();
        end
        rd_ready = 1'b0;

        // 4: continuous re-arm, identical second capture
        arm_cfg(2'd2, 1'b1, 32'hFFFF_FFFF, 32'h10, 4'd3);
        ctr = 0;
        run_ctr(20);
        chk("t4_done", 32'(state), 32'h3);
        drain_count(16, 4);
        chk("t4_rearmed", 32'(state), 32'h1);
        chk("t4_level0", 32'(level), 32'h0);
        chk("t4_wrap_clr", 32'(wrap), 32'h0);
        rd_ready = 1'b0;
        ctr = 0;
        run_ctr(20);
        chk("t4_done2", 32'(state), 32'h3);
        chk("t4_level2", 32'(level), 32'd16);
        chk("t4_wrap2", 32'(wrap), 32'h1);
        drain_count(16, 4);
        chk("t4_rearmed2", 32'(state), 32'h1);
        rd_ready = 1'b0;

        // 5: ready toggling in DONE
        arm_cfg(2'd0, 1'b0, 32'h0, 32'h0, 4'd5);
        for (int i = 0; i < 6; i++) begin rand_probes(); tick(); end
        chk("t5_level", 32'(level), 32'd6);
        prev_stall = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 12; i++) begin
            if (prev_stall) chk("t5_stable", rd_data, prev_data);
            rd_ready = (i % 2 == 0);
            prev_stall = !rd_ready;
            prev_data = rd_data;
            tick();
        end
        chk("t5_idle", 32'(state), 32'h0);
        chk("t5_data_zero", rd_data, 32'h0);
        rd_ready = 1'b0;

        // 6: reset mid-capture, then arm mid-DONE
        arm_cfg(2'd3, 1'b0, 32'h0, 32'h0, 4'd10);
        for (int i = 0; i < 4; i++) begin rand_probes(); tick(); end
        chk("t6_capture", 32'(state), 32'h2);
        do_reset();
        chk("t6_rst_state", 32'(state), 32'h0);
        chk("t6_rst_level", 32'(level), 32'h0);
        arm_cfg(2'd3, 1'b0, 32'h0, 32'h0, 4'd0);
        rand_probes();
        tick();
        chk("t6_done", 32'(state), 32'h3);
        arm_cfg(2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'd0);
        chk("t6_rearm", 32'(state), 32'h1);
        chk("t6_rearm_level", 32'(level), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rand_probes();
            rd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 2))
                    0: mask = 32'h0;
                    1: mask = 32'h1 << $urandom_range(0, 31);
                    default: mask = 32'h3 << $urandom_range(0, 30);
                endcase
                val = $urandom;
                ch_sel = 2'($urandom_range(0, 3));
                mode = 1'($urandom_range(0, 1));
                post = 4'($urandom_range(0, 15));
                arm = 1'b1;
                tick();
                arm = 1'b0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
